wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 82 ++++++++
 tb/tb_wb_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: single-port register-file writeback arbiter, ALU priority over a squashing memory-result queue.
module wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [31:0]                mem_data,
  output logic [4:0]                 rd_addr,
  output logic [31:0]                w_data,
  output logic                       w_en,
  input  logic [4:0]                 chk_addr,
  output logic                       chk_hit,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [4:0]    rd_q [DEPTH];
  logic [4:0]    rd_d [DEPTH];
  logic [31:0]   dat_q[DEPTH];
  logic [31:0]   dat_d[DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          w_en_q, w_en_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic          alu_sel, push, pop;
  always_comb begin
    alu_sel   = alu_valid && alu_rd != '0;
    mem_ready = !rst && cnt_q < CW'(DEPTH);
    push      = mem_valid && mem_ready && mem_rd != '0 && !(alu_sel && mem_rd == alu_rd);
    pop       = !alu_sel && cnt_q != '0;
    w_en_d    = alu_sel || pop;
    rd_addr_d = alu_sel ? alu_rd : pop ? rd_q[0] : rd_addr_q;
    w_data_d  = alu_sel ? alu_data : pop ? dat_q[0] : w_data_q;
    rd_d      = rd_q;
    dat_d     = dat_q;
    cnt_d     = '0;
    // survivors slide toward the head so the queue stays compact and ordered
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < cnt_q && !(pop && i == 0) && !(alu_sel && rd_q[i] == alu_rd)) begin
        rd_d[cnt_d[CW-2:0]]  = rd_q[i];
        dat_d[cnt_d[CW-2:0]] = dat_q[i];
        cnt_d = cnt_d + 1'b1;
      end
    if (push) begin
      rd_d[cnt_d[CW-2:0]]  = mem_rd;
      dat_d[cnt_d[CW-2:0]] = mem_data;
      cnt_d = cnt_d + 1'b1;
    end
  end
  always_comb begin
    chk_hit = w_en_q && rd_addr_q == chk_addr;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < cnt_q && rd_q[i] == chk_addr) chk_hit = 1'b1;
    chk_hit = chk_hit && chk_addr != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      w_en_q    <= 1'b0;
      rd_addr_q <= '0;
      w_data_q  <= '0;
      rd_q      <= '{default: '0};
      dat_q     <= '{default: '0};
    end else begin
      cnt_q     <= cnt_d;
      w_en_q    <= w_en_d;
      rd_addr_q <= rd_addr_d;
      w_data_q  <= w_data_d;
      rd_q      <= rd_d;
      dat_q     <= dat_d;
    end
  end
  assign w_en    = w_en_q;
  assign rd_addr = rd_addr_q;
  assign w_data  = w_data_q;
  assign q_count = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench; a queue-based reference model predicts every writeback cycle.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0] alu_rd = '0, mem_rd = '0, chk_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic mem_ready, w_en, chk_hit;
  logic [4:0] rd_addr;
  logic [31:0] w_data;
  logic [$clog2(DEPTH):0] q_count;
  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rd_addr(rd_addr), .w_data(w_data), .w_en(w_en), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .q_count(q_count)
  );
  always #5 clk = ~clk;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  typedef struct { logic we; logic [4:0] rd; logic [31:0] d; } out_t;
  ent_t mq[$];
  out_t eq[$];
  out_t mo = '{1'b0, 5'd0, 32'd0};
  int checks = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic model_hit(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (mo.we && mo.rd == a) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == a) return 1'b1;
    return 1'b0;
  endfunction
  // one cycle: drive inputs, check current state against the model, advance the model
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md, input logic [4:0] ca);
    ent_t keep[$];
    logic acc;
    @(negedge clk);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; chk_addr = ca;
    #1;
    chk("q_count", 32'(q_count), 32'(mq.size()));
    chk("mem_ready", 32'(mem_ready), 32'(!r && mq.size() < DEPTH));
    chk("chk_hit", 32'(chk_hit), 32'(model_hit(ca)));
    acc = mv && !r && mq.size() < DEPTH;
    if (r) begin
      mq.delete();
      mo = '{1'b0, 5'd0, 32'd0};
    end else if (av && ard != 0) begin
      mo = '{1'b1, ard, ad};
      foreach (mq[i]) if (mq[i].rd != ard) keep.push_back(mq[i]);
      mq = keep;
      if (acc && mrd != 0 && mrd != ard) mq.push_back('{mrd, md});
    end else begin
      if (mq.size() != 0) begin
        mo = '{1'b1, mq[0].rd, mq[0].d};
        void'(mq.pop_front());
      end else mo.we = 1'b0;
      if (acc && mrd != 0) mq.push_back('{mrd, md});
    end
    eq.push_back(mo);
  endtask
  always @(posedge clk) begin
    #1;
    if (eq.size() != 0) begin
      out_t e;
      e = eq.pop_front();
      chk("w_en", 32'(w_en), 32'(e.we));
      chk("rd_addr", 32'(rd_addr), 32'(e.rd));
      chk("w_data", w_data, e.d);
    end
  end
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 9, 32'h99, 1, 9, 32'h98, 9);
    step(0, 1, 5, 32'h11, 0, 0, 0, 5);
    step(0, 0, 0, 0, 0, 0, 0, 5);
    step(0, 1, 7, 32'h70, 1, 3, 32'hA, 3);
    step(0, 1, 7, 32'h71, 1, 4, 32'hB, 4);
    step(0, 1, 7, 32'h72, 1, 5, 32'hC, 5);
    step(0, 0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 1, 6, 32'h66, 6);
    step(0, 1, 6, 32'h22, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0, 0, 0, 6);
    step(0, 1, 0, 32'h33, 1, 0, 32'h44, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 1, 1, 32'h1, 1);
    step(0, 1, 8, 0, 1, 2, 32'h2, 2);
    step(1, 0, 0, 0, 1, 3, 32'h3, 1);
    step(0, 0, 0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 9, 0, 1, 10, 32'h100, 10);
    step(0, 1, 9, 0, 1, 11, 32'h101, 11);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 5'(12 + k), 32'h200 + k, 5'(12 + k));
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(eq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
